// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared FSM states, parity modes and parity helper for the serial receiver
package serial_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_PAR   = 3'd3,
      S_STOP  = 3'd4,
      S_BREAK = 3'd5
   } state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   // Parity bit the line must carry so that XOR(data, pbit) matches the mode
   function automatic logic exp_parity(input logic [15:0] i_data, input int i_mode);
      return (i_mode == PAR_ODD) ? ~(^i_data) : ^i_data;
   endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// rtl/serial_bit_timer.sv - OVS-cycle down-counter with half-bit preload, emits the bit sample strobe
// With OVS = 1 the counter stays at zero and the strobe is permanently high.
module serial_bit_timer #(
   parameter int OVS = 1
)(
   input  logic clk,
   input  logic arst_n,
   input  logic i_load,
   output logic o_strobe
);

   localparam int CW   = (OVS > 1) ? $clog2(OVS) : 1;
   localparam int HALF = (OVS > 1) ? (OVS / 2) - 1 : 0;

   logic [CW-1:0] r_cnt;

   // Preload lands the first strobe OVS/2 cycles after the start edge (mid start bit)
   always_ff @(posedge clk) begin
      if (!arst_n)
         r_cnt <= '0;
      else if (i_load)
         r_cnt <= CW'(HALF);
      else if (r_cnt == '0)
         r_cnt <= CW'(OVS - 1);
      else
         r_cnt <= r_cnt - CW'(1);
   end

   assign o_strobe = (r_cnt == '0);

endmodule

// File: rtl/serial_rx_param.sv
// rtl/serial_rx_param.sv - parametrised LSB-first async frame receiver with one-entry valid/ready output
// Optional SERIAL_RX_SYNC_EN: 2-flop synchronizer (reset high) on the line ahead of the FSM.
module serial_rx_param
   import serial_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int PARITY    = 2,
   parameter int STOP_BITS = 1,
   parameter int OVS       = 1
)(
   input  logic              clk,
   input  logic              arst_n,
   input  logic              in,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              perr,
   output logic              ferr,
   output logic              ovr_err,
   output logic              busy
);

   logic w_in;

`ifdef SERIAL_RX_SYNC_EN
   logic [1:0] r_sync;
   always_ff @(posedge clk) begin
      if (!arst_n) r_sync <= 2'b11;
      else         r_sync <= {r_sync[0], in};
   end
   assign w_in = r_sync[1];
`else
   assign w_in = in;
`endif

   state_t            r_state, w_state_next;
   logic [DATA_W-1:0] r_shift, w_shift_next;
   logic [DATA_W:0]   w_shift_in;
   logic [4:0]        r_cnt, w_cnt_next;
   logic              r_perr, w_perr_next;
   logic              r_ferr, w_ferr_next;
   logic              r_done, w_done_next;
   logic              w_timer_load, w_strobe;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_valid, r_out_perr, r_out_ferr, r_ovr;

   assign w_shift_in = {w_in, r_shift};

   serial_bit_timer #(.OVS(OVS)) u_timer (
      .clk      (clk),
      .arst_n   (arst_n),
      .i_load   (w_timer_load),
      .o_strobe (w_strobe)
   );

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         r_state <= S_IDLE;
         r_shift <= '0;
         r_cnt   <= '0;
         r_perr  <= 1'b0;
         r_ferr  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_shift <= w_shift_next;
         r_cnt   <= w_cnt_next;
         r_perr  <= w_perr_next;
         r_ferr  <= w_ferr_next;
         r_done  <= w_done_next;
      end
   end

   // IDLE and BREAK look at the line every cycle; the other states only on the strobe
   always_comb begin
      w_state_next = r_state;
      w_shift_next = r_shift;
      w_cnt_next   = r_cnt;
      w_perr_next  = r_perr;
      w_ferr_next  = r_ferr;
      w_done_next  = 1'b0;
      w_timer_load = 1'b0;
      case (r_state)
         S_IDLE: if (!w_in) begin
            w_timer_load = 1'b1;
            w_perr_next  = 1'b0;
            w_ferr_next  = 1'b0;
            w_cnt_next   = '0;
            w_state_next = (OVS == 1) ? S_DATA : S_START;
         end
         S_START: if (w_strobe) w_state_next = w_in ? S_IDLE : S_DATA;
         S_DATA: if (w_strobe) begin
            w_shift_next = w_shift_in[DATA_W:1];
            if (r_cnt == 5'(DATA_W - 1)) begin
               w_cnt_next   = '0;
               w_state_next = (PARITY != PAR_NONE) ? S_PAR : S_STOP;
            end else begin
               w_cnt_next = r_cnt + 5'd1;
            end
         end
         S_PAR: if (w_strobe) begin
            w_perr_next  = (w_in != exp_parity(16'(r_shift), PARITY));
            w_state_next = S_STOP;
         end
         S_STOP: if (w_strobe) begin
            w_ferr_next = r_ferr | ~w_in;
            if (r_cnt == 5'(STOP_BITS - 1)) begin
               w_done_next  = 1'b1;
               w_cnt_next   = '0;
               w_state_next = w_in ? S_IDLE : S_BREAK;
            end else begin
               w_cnt_next = r_cnt + 5'd1;
            end
         end
         S_BREAK: if (w_in) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // A completed frame may replace the held one only if the slot is empty or drains this cycle
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_out_perr  <= 1'b0;
         r_out_ferr  <= 1'b0;
         r_ovr       <= 1'b0;
      end else begin
         r_ovr <= 1'b0;
         if (r_done) begin
            if (!r_out_valid || out_ready) begin
               r_out_data  <= r_shift;
               r_out_perr  <= r_perr;
               r_out_ferr  <= r_ferr;
               r_out_valid <= 1'b1;
            end else begin
               r_ovr <= 1'b1;
            end
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign perr      = r_out_perr;
   assign ferr      = r_out_ferr;
   assign ovr_err   = r_ovr;
   assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_rx_param.sv
// tb/tb_serial_rx_param.sv - bench for serial_rx_param: ch0 OVS=1 even parity 1 stop, ch1 OVS=4 odd parity 2 stop
module tb_serial_rx_param;

`ifdef SERIAL_RX_SYNC_EN
   localparam int SL = 2;
`else
   localparam int SL = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       arst_n = 1'b0;
   logic       in0 = 1'b1, in1 = 1'b1, rdy0 = 1'b1, rdy1 = 1'b1;
   logic [7:0] data0, data1;
   logic       v0, v1, pe0, pe1, fe0, fe1, ov0, ov1, busy0, busy1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_t0 = 0;
   bit chk_en = 1'b0;

   serial_rx_param #(.DATA_W(8), .PARITY(1), .STOP_BITS(1), .OVS(1)) dut0 (
      .clk(clk), .arst_n(arst_n), .in(in0), .out_data(data0), .out_valid(v0),
      .out_ready(rdy0), .perr(pe0), .ferr(fe0), .ovr_err(ov0), .busy(busy0));

   serial_rx_param #(.DATA_W(8), .PARITY(2), .STOP_BITS(2), .OVS(4)) dut1 (
      .clk(clk), .arst_n(arst_n), .in(in1), .out_data(data1), .out_valid(v1),
      .out_ready(rdy1), .perr(pe1), .ferr(fe1), .ovr_err(ov1), .busy(busy1));

   typedef struct {
      int         ch;
      int         at;
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } ev_t;

   ev_t        pend[$];
   logic       mv[2], mpe[2], mfe[2], mov[2];
   logic [7:0] md[2];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_to(input int target);
      while (cyc < target) step();
   endtask

   task automatic drive(input int ch, input logic val);
      if (ch == 0) in0 = val;
      else         in1 = val;
   endtask

   // Frame arrival model: each scheduled frame lands in the slot at (last sample + 1)
   initial begin : model
      int  hit;
      logic rdy;
      forever begin
         @(posedge clk);
         cyc++;
         if (!arst_n) begin
            for (int c = 0; c < 2; c++) begin
               mv[c] = 1'b0; md[c] = 8'h00; mpe[c] = 1'b0; mfe[c] = 1'b0; mov[c] = 1'b0;
            end
            pend.delete();
         end else begin
            for (int c = 0; c < 2; c++) begin
               hit = -1;
               rdy = (c == 0) ? rdy0 : rdy1;
               foreach (pend[i]) if (pend[i].ch == c && pend[i].at == cyc) hit = i;
               mov[c] = 1'b0;
               if (hit >= 0) begin
                  if (!mv[c] || rdy) begin
                     mv[c] = 1'b1; md[c] = pend[hit].d; mpe[c] = pend[hit].pe; mfe[c] = pend[hit].fe;
                  end else begin
                     mov[c] = 1'b1;
                  end
                  pend.delete(hit);
               end else if (mv[c] && rdy) begin
                  mv[c] = 1'b0;
               end
            end
         end
      end
   end

   initial begin : compare
      logic       av, ape, afe, aov;
      logic [7:0] ad;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            for (int c = 0; c < 2; c++) begin
               av  = (c == 0) ? v0 : v1;
               ad  = (c == 0) ? data0 : data1;
               ape = (c == 0) ? pe0 : pe1;
               afe = (c == 0) ? fe0 : fe1;
               aov = (c == 0) ? ov0 : ov1;
               chk($sformatf("valid_ch%0d", c), av, mv[c]);
               chk($sformatf("ovr_ch%0d", c), aov, mov[c]);
               if (mv[c]) begin
                  chk($sformatf("data_ch%0d", c), ad, md[c]);
                  chk($sformatf("perr_ch%0d", c), ape, mpe[c]);
                  chk($sformatf("ferr_ch%0d", c), afe, mfe[c]);
               end
            end
         end
      end
   end

   // Drives start, 8 data bits LSB-first, parity bit pb and stop bits; schedules the expected result
   task automatic send(input int ch, input logic [7:0] d, input logic pb, input logic [1:0] stp,
                       input bit exp_out, input int rst_bit, input logic idle_val);
      int   ovs, nstop, n, t0, ones;
      logic bits[12];
      ev_t  e;
      ovs   = (ch == 0) ? 1 : 4;
      nstop = (ch == 0) ? 1 : 2;
      n     = 10 + nstop;
      t0    = cyc + 1 + SL;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = d[i];
      bits[9]  = pb;
      bits[10] = stp[0];
      bits[11] = stp[1];
      if (exp_out) begin
         ones = $countones(d) + int'(pb);
         e.ch = ch;
         e.at = t0 + ((ovs > 1) ? ovs / 2 : 0) + (n - 1) * ovs + 1;
         e.d  = d;
         e.pe = (ch == 0) ? (ones % 2 != 0) : (ones % 2 != 1);
         e.fe = (stp[0] == 1'b0) || (nstop == 2 && stp[1] == 1'b0);
         pend.push_back(e);
      end
      for (int k = 0; k < n; k++) begin
         drive(ch, bits[k]);
         if (k == rst_bit) arst_n = 1'b0;
         repeat (ovs) step();
         arst_n = 1'b1;
      end
      drive(ch, idle_val);
      last_t0 = t0;
   endtask

   initial begin : stim
      int t0;
      step();
      chk_en = 1'b1;
      step();
      chk("rst_data", data0, 8'h00);
      chk("rst_valid", v0, 1'b0);
      chk("rst_busy", busy0, 1'b0);
      chk("rst_ovr", ov0, 1'b0);
      chk("rst_valid1", v1, 1'b0);
      arst_n = 1'b1;
      repeat (3) step();

      send(0, 8'hA5, 1'b0, 2'b11, 1'b1, -1, 1'b1);
      wait_to(last_t0 + 11);
      chk("a5_valid", v0, 1'b1);
      chk("a5_data", data0, 8'hA5);
      chk("a5_perr", pe0, 1'b0);
      chk("a5_ferr", fe0, 1'b0);
      repeat (3) step();

      send(0, 8'h3C, 1'b1, 2'b11, 1'b1, -1, 1'b1);
      wait_to(last_t0 + 11);
      chk("3c_data", data0, 8'h3C);
      chk("3c_perr", pe0, 1'b1);
      chk("3c_ferr", fe0, 1'b0);
      repeat (3) step();

      send(0, 8'h01, 1'b1, 2'b10, 1'b1, -1, 1'b0);
      wait_to(last_t0 + 11);
      chk("brk_data", data0, 8'h01);
      chk("brk_ferr", fe0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         chk("brk_busy", busy0, 1'b1);
         step();
      end
      in0 = 1'b1;
      repeat (1 + SL) step();
      chk("brk_exit_busy", busy0, 1'b0);
      repeat (2) step();
      send(0, 8'h55, 1'b0, 2'b11, 1'b1, -1, 1'b1);
      wait_to(last_t0 + 11);
      chk("55_data", data0, 8'h55);
      chk("55_ferr", fe0, 1'b0);
      repeat (3) step();

      rdy0 = 1'b0;
      send(0, 8'h11, 1'b0, 2'b11, 1'b1, -1, 1'b1);
      send(0, 8'h22, 1'b0, 2'b11, 1'b1, -1, 1'b1);
      wait_to(last_t0 + 11);
      chk("ovr_pulse", ov0, 1'b1);
      chk("ovr_keep_data", data0, 8'h11);
      step();
      chk("ovr_one_cycle", ov0, 1'b0);
      rdy0 = 1'b1;
      step();
      rdy0 = 1'b0;
      chk("ready_clears", v0, 1'b0);

      t0 = cyc + 1 + SL;
      in1 = 1'b0;
      step();
      in1 = 1'b1;
      wait_to(t0);
      chk("glitch_busy", busy1, 1'b1);
      wait_to(t0 + 2);
      chk("glitch_idle", busy1, 1'b0);
      repeat (4) step();
      send(1, 8'hC3, 1'b1, 2'b11, 1'b1, -1, 1'b1);
      wait_to(last_t0 + 47);
      chk("c3_valid", v1, 1'b1);
      chk("c3_data", data1, 8'hC3);
      chk("c3_perr", pe1, 1'b0);
      repeat (3) step();
      send(1, 8'h0F, 1'b0, 2'b11, 1'b1, -1, 1'b1);
      wait_to(last_t0 + 47);
      chk("0f_perr", pe1, 1'b1);
      repeat (3) step();
      send(1, 8'h81, 1'b1, 2'b01, 1'b1, -1, 1'b1);
      wait_to(last_t0 + 47);
      chk("81_data", data1, 8'h81);
      chk("81_ferr", fe1, 1'b1);
      repeat (4) step();
      chk("81_idle", busy1, 1'b0);

      send(0, 8'h5A, 1'b0, 2'b11, 1'b1, -1, 1'b1);
      send(0, 8'hE5, 1'b1, 2'b11, 1'b0, 5, 1'b1);
      chk("arst_valid", v0, 1'b0);
      chk("arst_data", data0, 8'h00);
      chk("arst_busy", busy0, 1'b0);
      chk("arst_perr", pe0, 1'b0);
      rdy0 = 1'b1;
      repeat (3) step();
      send(0, 8'h96, 1'b0, 2'b11, 1'b1, -1, 1'b1);
      wait_to(last_t0 + 11);
      chk("96_data", data0, 8'h96);
      chk("96_valid", v0, 1'b1);
      repeat (5) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
